// File: rtl/led_pattern_ctrl_if.sv
// Board-side signal bundle for led_pattern_ctrl: raw push button in, LED bank and mode code out.
// The slave modport is the pattern engine; the master modport is the board/bench side.
interface led_pattern_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             button_export;
  logic [WIDTH-1:0] led_out_export;
  logic [1:0]       mode_export;

  modport master (
    output button_export,
    input  led_out_export,
    input  mode_export
  );

  modport slave (
    input  button_export,
    output led_out_export,
    output mode_export
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: debounced button cycles BLINK/SHIFT/COUNT (plus BREATHE when
// LED_PATTERN_BREATHE_EN is defined); a prescaler paces the pattern steps.
module led_pattern_ctrl #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 12_500_000,
  parameter int DB_DIV   = 1_000_000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  led_pattern_ctrl_if.slave io
);
  localparam int SW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DB_DIV);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_DIV - 1);

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_SHIFT   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic             sync1_r;
  logic             sync2_r;
  logic             db_level_r;
  logic             db_prev_r;
  logic             press_r;
  logic [DW-1:0]    db_cnt_r;
  logic [SW-1:0]    pre_cnt_r;
  logic [SW-1:0]    pre_cnt_next_s;
  logic             tick_s;
  mode_e            mode_r;
  mode_e            mode_next_s;
  logic [WIDTH-1:0] pattern_r;
  logic [WIDTH-1:0] pattern_next_s;
  logic [WIDTH-1:0] led_r;
  logic [WIDTH-1:0] led_next_s;

`ifdef LED_PATTERN_BREATHE_EN
  logic [3:0] duty_r;
  logic [3:0] duty_next_s;
  logic       duty_up_r;
  logic       duty_up_next_s;
  logic [3:0] pwm_cnt_r;
  logic [3:0] pwm_next_s;
`endif

  assign tick_s = (pre_cnt_r == STEP_LAST);

  // Button synchroniser, debounce filter and falling-edge press detector
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      db_level_r <= 1'b1;
      db_prev_r  <= 1'b1;
      press_r    <= 1'b0;
      db_cnt_r   <= {DW{1'b0}};
    end else begin
      sync1_r   <= io.button_export;
      sync2_r   <= sync1_r;
      db_prev_r <= db_level_r;
      press_r   <= db_prev_r & ~db_level_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r <= {DW{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= {DW{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DW'(1'b1);
      end
    end
  end

  // Mode/pattern state register with the LED drive registered alongside
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mode_r    <= MODE_BLINK;
      pattern_r <= {WIDTH{1'b0}};
      led_r     <= {WIDTH{1'b0}};
      pre_cnt_r <= {SW{1'b0}};
    end else begin
      mode_r    <= mode_next_s;
      pattern_r <= pattern_next_s;
      led_r     <= led_next_s;
      pre_cnt_r <= pre_cnt_next_s;
    end
  end

  // Next mode, pattern and prescaler; a press overrides a coincident tick
  always_comb begin
    mode_next_s    = mode_r;
    pattern_next_s = pattern_r;
    pre_cnt_next_s = pre_cnt_r + SW'(1'b1);
    if (press_r) begin
      pre_cnt_next_s = {SW{1'b0}};
      case (mode_r)
        MODE_BLINK: mode_next_s = MODE_SHIFT;
        MODE_SHIFT: mode_next_s = MODE_COUNT;
`ifdef LED_PATTERN_BREATHE_EN
        MODE_COUNT: mode_next_s = MODE_BREATHE;
`else
        MODE_COUNT: mode_next_s = MODE_BLINK;
`endif
        default:    mode_next_s = MODE_BLINK;
      endcase
      if (mode_next_s == MODE_SHIFT) begin
        pattern_next_s = WIDTH'(1'b1);
      end else begin
        pattern_next_s = {WIDTH{1'b0}};
      end
    end else if (tick_s) begin
      pre_cnt_next_s = {SW{1'b0}};
      case (mode_r)
        MODE_BLINK: pattern_next_s = ~pattern_r;
        MODE_SHIFT: pattern_next_s = {pattern_r[WIDTH-2:0], pattern_r[WIDTH-1]};
        MODE_COUNT: pattern_next_s = pattern_r + WIDTH'(1'b1);
        default:    pattern_next_s = pattern_r;
      endcase
    end else begin
      pattern_next_s = pattern_r;
    end
  end

`ifdef LED_PATTERN_BREATHE_EN
  // Breathe duty: triangle walk 0..15..0 without repeating the endpoints
  always_comb begin
    duty_next_s    = duty_r;
    duty_up_next_s = duty_up_r;
    pwm_next_s     = pwm_cnt_r + 4'd1;
    if (press_r) begin
      if (mode_next_s == MODE_BREATHE) begin
        duty_next_s    = 4'd0;
        duty_up_next_s = 1'b1;
        pwm_next_s     = 4'd0;
      end else begin
        duty_next_s = duty_r;
      end
    end else if (tick_s && (mode_r == MODE_BREATHE)) begin
      if (duty_up_r) begin
        if (duty_r == 4'd15) begin
          duty_next_s    = 4'd14;
          duty_up_next_s = 1'b0;
        end else begin
          duty_next_s = duty_r + 4'd1;
        end
      end else if (duty_r == 4'd0) begin
        duty_next_s    = 4'd1;
        duty_up_next_s = 1'b1;
      end else begin
        duty_next_s = duty_r - 4'd1;
      end
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Breathe duty and PWM phase registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      duty_r    <= 4'd0;
      duty_up_r <= 1'b1;
      pwm_cnt_r <= 4'd0;
    end else begin
      duty_r    <= duty_next_s;
      duty_up_r <= duty_up_next_s;
      pwm_cnt_r <= pwm_next_s;
    end
  end
`endif

  // LED drive source: PWM compare in BREATHE, otherwise the pattern itself
  always_comb begin
    led_next_s = pattern_next_s;
`ifdef LED_PATTERN_BREATHE_EN
    if (mode_next_s == MODE_BREATHE) begin
      led_next_s = {WIDTH{pwm_next_s < duty_next_s}};
    end else begin
      led_next_s = pattern_next_s;
    end
`endif
  end

  assign io.led_out_export = led_r;
  assign io.mode_export    = mode_r;
endmodule
